regfile_2w_scoreboard: RTL and testbench
========================================

Name: regfile_2w_scoreboard

Overview:
- Parametrised successor of the CPU register file.
- Provides 2 combinational read ports and 2 clocked write ports: W3 for the ALU result and W4 for the load/base-update return.
- Adds a per-register pending (scoreboard) bit so the pipeline can stall on operands of outstanding loads.
- Sits between decode (reads, pending set) and writeback (W3/W4).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, register address width; register count NREGS = 2**ADDR_W.
- PC_IDX, 15, index of the program-counter register; not physically stored.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- a1  in  ADDR_W  read address, port 1.
- a2  in  ADDR_W  read address, port 2.
- re1  in  1  port 1 operand is used this cycle (stall qualification only).
- re2  in  1  port 2 operand is used this cycle.
- rd1  out  DATA_W  read data, port 1.
- rd2  out  DATA_W  read data, port 2.
- we3  in  1  write enable, ALU port.
- a3  in  ADDR_W  write address, ALU port.
- wd3  in  DATA_W  write data, ALU port.
- we4  in  1  write enable, load-return port; also clears the pending bit of a4.
- a4  in  ADDR_W  write address, load port.
- wd4  in  DATA_W  write data, load port.
- r15  in  DATA_W  current PC+8 from fetch.
- sb_set  in  1  mark register sb_addr pending (load issued).
- sb_addr  in  ADDR_W  register to mark pending.
- busy1  out  1  register a1 is pending.
- busy2  out  1  register a2 is pending.
- stall  out  1  (re1 & busy1) | (re2 & busy2).
- pend_cnt  out  ADDR_W+1  number of pending registers.

Behaviour:
- Reset: all registers := 0, all pending bits := 0, pend_cnt := 0. With reset asserted, rd1/rd2 read 0 except at PC_IDX, which reads r15; busy1/busy2/stall are 0. Reset asserted mid-cycle takes effect immediately and overrides any write or set in flight.
- Reads: combinational, zero latency. If ax == PC_IDX, rdx = r15; otherwise rdx = stored value.
- Writes: on the rising clk edge when wex=1. A write to PC_IDX is discarded; data is never stored.
- Write collision (we3 & we4 & a3==a4): W3 data wins (younger instruction). The W4 pending-clear still applies.
- Pending set: on the edge when sb_set=1 and sb_addr != PC_IDX, pend[sb_addr] := 1. A set with sb_addr == PC_IDX is ignored.
- Pending clear: on the edge when we4=1, pend[a4] := 0. we3 never clears pending.
- Set and clear on the same address in the same cycle: set wins (a new load is issued behind the returning one), so the bit stays 1.
- Set on an already pending register: no change, no double count.
- Clear on a non-pending register: no change.
- busyx = pend[ax] (registered state). busyx is always 0 when ax == PC_IDX.
- pend_cnt: registered popcount of pend, updated on the same edge as pend. Range 0..NREGS-1; it never wraps because PC_IDX cannot be pending.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- When defined: write-first forwarding.
  - If a same-cycle write hits ax (not PC_IDX), rdx returns the data being written, W3 having priority over W4.
  - If we4 & a4==ax, busyx is forced to 0 in the same cycle, unless sb_set & sb_addr==ax in that cycle.
  - stall follows the forwarded busy values.
- When undefined: reads return the pre-edge stored value, and busy deasserts the cycle after the clearing we4.
- pend_cnt is unaffected by the macro in both cases.

Test Plan:
- Reset with all regs written to 0xFFFFFFFF -> rd1(a1=3)=0, pend_cnt=0, stall=0; r15=0x108 with a2=15 -> rd2=0x108.
- we3 a3=2 wd3=0xA5A5A5A5, next cycle a1=2 -> rd1=0xA5A5A5A5. we3 a3=15 wd3=0x1 -> r15 input still returned at a1=15, nothing stored.
- we3 a3=5 wd3=0x11 and we4 a4=5 wd4=0x22 in the same cycle -> rd1(a1=5)=0x11 afterward.
- sb_set sb_addr=7; next cycle a1=7 re1=1 -> busy1=1, stall=1, pend_cnt=1. we4 a4=7 wd4=0x77 -> without bypass: stall=1 in that cycle, 0 next cycle, rd1=0x77. With REGFILE_BYPASS_EN: stall=0 and rd1=0x77 in the same cycle.
- sb_set sb_addr=4 and we4 a4=4 in the same cycle while pend[4]=1 -> pend[4] stays 1, pend_cnt unchanged. sb_set sb_addr=15 -> ignored, pend_cnt unchanged.
- Set pending on regs 0..14 sequentially -> pend_cnt=15. Assert reset asynchronously mid-cycle -> pend_cnt=0, busy1=busy2=0 immediately, all regs read 0.

Source files
------------

// File: rtl/regfile_2w_scoreboard.sv
// Register file: 2 combinational reads, 2 clocked writes (W3 ALU, W4 load), per-register pending bits.
// Optional write-first forwarding of data and pending-clear when REGFILE_BYPASS_EN is defined.
module regfile_2w_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_IDX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic              re1,
  input  logic              re2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              we4,
  input  logic [ADDR_W-1:0] a4,
  input  logic [DATA_W-1:0] wd4,
  input  logic [DATA_W-1:0] r15,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  pend_nxt;

  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  logic [1:0]        busy_v;

  function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Set is applied after clear so a load issued behind a returning one keeps the bit.
  always_comb begin
    pend_nxt = pend;
    if (we4) pend_nxt[a4] = 1'b0;
    if (sb_set && (sb_addr != PC_A)) pend_nxt[sb_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= popcount(pend_nxt);
    end
  end

  // W3 wins a collision with W4; the PC slot is never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i != PC_IDX) begin
          if (we3 && (a3 == ADDR_W'(i))) begin
            mem[i] <= wd3;
          end else if (we4 && (a4 == ADDR_W'(i))) begin
            mem[i] <= wd4;
          end
        end
      end
    end
  end

  assign ra[0] = a1;
  assign ra[1] = a2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rd[p] = mem[ra[p]];
      if (ra[p] == PC_A) begin
        rd[p] = r15;
`ifdef REGFILE_BYPASS_EN
      end else if (!reset && we3 && (a3 == ra[p])) begin
        rd[p] = wd3;
      end else if (!reset && we4 && (a4 == ra[p])) begin
        rd[p] = wd4;
`endif
      end
    end

`ifdef REGFILE_BYPASS_EN
    // A returning load releases its consumer in the same cycle unless a new load re-marks it.
    assign busy_v[p] = pend[ra[p]] &
                       ~(we4 && (a4 == ra[p]) && !(sb_set && (sb_addr == ra[p])));
`else
    assign busy_v[p] = pend[ra[p]];
`endif
  end

  assign rd1   = rd[0];
  assign rd2   = rd[1];
  assign busy1 = busy_v[0];
  assign busy2 = busy_v[1];
  assign stall = (re1 & busy1) | (re2 & busy2);

endmodule

// File: tb/tb_regfile_2w_scoreboard.sv
// Directed bench for regfile_2w_scoreboard; expectations follow the REGFILE_BYPASS_EN setting.
module tb_regfile_2w_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  a1, a2, a3, a4, sb_addr;
  logic        re1, re2, we3, we4, sb_set;
  logic [31:0] wd3, wd4, r15;
  logic [31:0] rd1, rd2;
  logic        busy1, busy2, stall;
  logic [4:0]  pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_2w_scoreboard #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15)) dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .re1(re1), .re2(re2),
    .rd1(rd1), .rd2(rd2), .we3(we3), .a3(a3), .wd3(wd3), .we4(we4),
    .a4(a4), .wd4(wd4), .r15(r15), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy1(busy1), .busy2(busy2), .stall(stall), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    we3 = 0; we4 = 0; sb_set = 0; re1 = 0; re2 = 0;
    a3 = 0; a4 = 0; wd3 = 0; wd4 = 0; sb_addr = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 15; i++) begin
      we3 = 1; a3 = 4'(i); wd3 = 32'hFFFF_FFFF; step();
    end
    idle();
    a1 = 3; #1;
    n_checks++; if (rd1 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL pre_reset_rd1: got %h exp ffffffff", rd1); end
    @(negedge clk); #2;
    reset = 1; r15 = 32'h108; a2 = 15; re1 = 1; re2 = 1; #1;
    n_checks++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1: got %h exp 0", rd1); end
    n_checks++; if (rd2 !== 32'h108) begin n_fail++; $display("FAIL reset_rd2_pc: got %h exp 108", rd2); end
    n_checks++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_pend_cnt: got %0d exp 0", pend_cnt); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", stall); end
    @(negedge clk); reset = 0; re1 = 0; re2 = 0; step();
  endtask

  task automatic test_write_read();
    we3 = 1; a3 = 2; wd3 = 32'hA5A5_A5A5; a1 = 2; #1;
`ifdef REGFILE_BYPASS_EN
    n_checks++; if (rd1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL w3_same_cycle_fwd: got %h exp a5a5a5a5", rd1); end
`else
    n_checks++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL w3_same_cycle_old: got %h exp 0", rd1); end
`endif
    step(); idle(); #1;
    n_checks++; if (rd1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL w3_write_read: got %h exp a5a5a5a5", rd1); end
    we3 = 1; a3 = 15; wd3 = 32'h1; r15 = 32'h200; step(); idle();
    a1 = 15; a2 = 2; #1;
    n_checks++; if (rd1 !== 32'h200) begin n_fail++; $display("FAIL pc_write_discard: got %h exp 200", rd1); end
    r15 = 32'h300; #1;
    n_checks++; if (rd1 !== 32'h300) begin n_fail++; $display("FAIL pc_tracks_r15: got %h exp 300", rd1); end
    n_checks++; if (rd2 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL pc_write_no_side: got %h exp a5a5a5a5", rd2); end
  endtask

  task automatic test_collision();
    we3 = 1; a3 = 5; wd3 = 32'h11; we4 = 1; a4 = 5; wd4 = 32'h22; step(); idle();
    a1 = 5; #1;
    n_checks++; if (rd1 !== 32'h11) begin n_fail++; $display("FAIL collision_w3_wins: got %h exp 11", rd1); end
    we4 = 1; a4 = 6; wd4 = 32'h66; step(); idle();
    a2 = 6; #1;
    n_checks++; if (rd2 !== 32'h66) begin n_fail++; $display("FAIL w4_write_read: got %h exp 66", rd2); end
  endtask

  task automatic test_scoreboard();
    sb_set = 1; sb_addr = 7; step(); idle();
    a1 = 7; re1 = 1; #1;
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy1: got %b exp 1", busy1); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sb_stall: got %b exp 1", stall); end
    n_checks++; if (pend_cnt !== 5'd1) begin n_fail++; $display("FAIL sb_pend_cnt: got %0d exp 1", pend_cnt); end
    re1 = 0; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sb_stall_unqualified: got %b exp 0", stall); end
    re1 = 1; we4 = 1; a4 = 7; wd4 = 32'h77; #1;
`ifdef REGFILE_BYPASS_EN
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL clr_stall_fwd: got %b exp 0", stall); end
    n_checks++; if (rd1 !== 32'h77) begin n_fail++; $display("FAIL clr_rd1_fwd: got %h exp 77", rd1); end
`else
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL clr_stall_same: got %b exp 1", stall); end
    n_checks++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL clr_rd1_same: got %h exp 0", rd1); end
`endif
    step(); we4 = 0; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL clr_stall_next: got %b exp 0", stall); end
    n_checks++; if (rd1 !== 32'h77) begin n_fail++; $display("FAIL clr_rd1_next: got %h exp 77", rd1); end
    n_checks++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL clr_pend_cnt: got %0d exp 0", pend_cnt); end
    idle();
    sb_set = 1; sb_addr = 8; step(); idle();
    we3 = 1; a3 = 8; wd3 = 32'h88; step(); idle();
    a2 = 8; #1;
    n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL w3_no_clear: got %b exp 1", busy2); end
    we4 = 1; a4 = 8; step(); idle(); #1;
    n_checks++; if (busy2 !== 1'b0 || pend_cnt !== 5'd0) begin n_fail++; $display("FAIL w4_clear_8: got busy2=%b cnt=%0d exp 0/0", busy2, pend_cnt); end
  endtask

  task automatic test_set_clear_same();
    sb_set = 1; sb_addr = 4; step(); idle();
    a1 = 4; re1 = 1;
    sb_set = 1; sb_addr = 4; we4 = 1; a4 = 4; wd4 = 32'h44; #1;
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL setclr_busy_same: got %b exp 1", busy1); end
    step(); idle(); re1 = 1; #1;
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL setclr_set_wins: got %b exp 1", busy1); end
    n_checks++; if (pend_cnt !== 5'd1) begin n_fail++; $display("FAIL setclr_pend_cnt: got %0d exp 1", pend_cnt); end
    n_checks++; if (rd1 !== 32'h44) begin n_fail++; $display("FAIL setclr_data: got %h exp 44", rd1); end
    sb_set = 1; sb_addr = 4; step(); idle(); #1;
    n_checks++; if (pend_cnt !== 5'd1) begin n_fail++; $display("FAIL double_set: got %0d exp 1", pend_cnt); end
    sb_set = 1; sb_addr = 15; step(); idle();
    a1 = 15; re1 = 1; #1;
    n_checks++; if (pend_cnt !== 5'd1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL pc_set_ignored: got cnt=%0d busy1=%b exp 1/0", pend_cnt, busy1); end
    we4 = 1; a4 = 9; wd4 = 32'h99; step(); idle(); #1;
    n_checks++; if (pend_cnt !== 5'd1) begin n_fail++; $display("FAIL clear_nonpending: got %0d exp 1", pend_cnt); end
    we4 = 1; a4 = 4; step(); idle(); #1;
    n_checks++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL clear_4: got %0d exp 0", pend_cnt); end
  endtask

  task automatic test_fill_and_async_reset();
    for (int i = 0; i < 15; i++) begin
      sb_set = 1; sb_addr = 4'(i); step();
    end
    idle(); #1;
    n_checks++; if (pend_cnt !== 5'd15) begin n_fail++; $display("FAIL fill_pend_cnt: got %0d exp 15", pend_cnt); end
    a1 = 0; a2 = 14; #1;
    n_checks++; if (busy1 !== 1'b1 || busy2 !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %b%b exp 11", busy1, busy2); end
    a1 = 2; #1;
    n_checks++; if (rd1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL pre_async_rd1: got %h exp a5a5a5a5", rd1); end
    we3 = 1; a3 = 3; wd3 = 32'hDEAD_BEEF; we4 = 1; a4 = 0; sb_set = 1; sb_addr = 1;
    #2 reset = 1; #1;
    n_checks++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL async_pend_cnt: got %0d exp 0", pend_cnt); end
    n_checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b%b exp 00", busy1, busy2); end
    for (int i = 0; i < 15; i++) begin
      a1 = 4'(i); #1;
      n_checks++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL async_reg%0d: got %h exp 0", i, rd1); end
    end
    step();
    n_checks++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_holds_over_edge: got %0d exp 0", pend_cnt); end
    idle(); @(negedge clk); reset = 0; step();
    a1 = 3; #1;
    n_checks++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL post_reset_reg3: got %h exp 0", rd1); end
  endtask

  initial begin
    reset = 1; idle(); a1 = 0; a2 = 0; r15 = 0;
    #12 reset = 0;
    @(negedge clk);
    step();
    test_reset();
    test_write_read();
    test_collision();
    test_scoreboard();
    test_set_clear_same();
    test_fill_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
